// File: rtl/cdc_2phase_dst_fifo.sv
// Destination half of a 2-phase (toggle) clock-domain crossing with a small
// first-word-fall-through receive buffer that absorbs consumer stalls.
module cdc_2phase_dst_fifo #(
    parameter int DATA_WIDTH  = 41,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         async_req_i,
    output logic                         async_ack_o,
    input  logic [DATA_WIDTH-1:0]        async_data_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    (* async_reg = "true", dont_touch = "true" *)
    logic [SYNC_STAGES-1:0] req_sync_q;

    logic                  req_sync;
    logic                  ack_q;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic pending;
    logic full;
    logic push;
    logic pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], async_req_i};
        end
    end

    assign req_sync = req_sync_q[SYNC_STAGES-1];

    // Full uses the registered count, so a slot freed by a pop is only
    // reused on the following cycle (no full-buffer bypass).
    assign pending = (req_sync != ack_q);
    assign full    = (count == CW'(DEPTH));
    assign push    = pending && !full && !clear_i;

    // Consumer side: a word transfers on every edge where valid_o && ready_i;
    // data_o must be held by nobody, it simply shows the head while valid_o.
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i && !clear_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            ack_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ack_q  <= ~ack_q;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is left unreset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= async_data_i;
        end
    end

    assign data_o      = mem[rd_ptr];
    assign async_ack_o = ack_q;
    assign count_o     = count;

endmodule

// File: tb/tb_cdc_2phase_dst_fifo.sv
// Directed bench for cdc_2phase_dst_fifo: latency, fill/stall, ordering with
// wrap, simultaneous push/pop, clear and mid-transfer reset.
module tb_cdc_2phase_dst_fifo;

    localparam int DW = 41;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          clear_i = 1'b0;
    logic          async_req_i = 1'b0;
    logic          async_ack_o;
    logic [DW-1:0] async_data_i = '0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [CW-1:0] count_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int ack_edges = 0;

    logic [DW-1:0] exp_q[$];

    cdc_2phase_dst_fifo #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2),
        .DEPTH      (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .async_req_i (async_req_i),
        .async_ack_o (async_ack_o),
        .async_data_i(async_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count_o     (count_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(async_ack_o) ack_edges++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        ready_i      = 1'b0;
        async_req_i  = 1'b0;
        async_data_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Source-side driver: present a word, toggle the request, wait for the ack.
    task automatic send_wait(input logic [DW-1:0] d);
        async_data_i = d;
        async_req_i  = ~async_req_i;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (async_ack_o == async_req_i) break;
        end
        n_cmp++;
        if (async_ack_o !== async_req_i) begin
            n_fail++;
            $display("FAIL send_wait_ack: ack=%0b req=%0b data=%h", async_ack_o, async_req_i, d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 3;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
        if (async_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b want 0", async_ack_o); end
    endtask

    task automatic test_single_word();
        async_data_i = 41'h0AB;
        async_req_i  = 1'b1;
        tick();
        tick();
        n_cmp += 2;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %0b want 0", valid_o); end
        if (async_ack_o !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: got %0b want 0", async_ack_o); end
        tick();
        n_cmp += 4;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", valid_o); end
        if (data_o !== 41'h0AB) begin n_fail++; $display("FAIL single_data: got %h want 0ab", data_o); end
        if (async_ack_o !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %0b want 1", async_ack_o); end
        if (count_o !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count_o); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        n_cmp += 2;
        if (count_o !== 3'd0) begin n_fail++; $display("FAIL single_pop_count: got %0d want 0", count_o); end
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %0b want 0", valid_o); end
    endtask

    task automatic test_fill_stall();
        int   base;
        logic ack_hold;
        base = ack_edges;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            send_wait(DW'(32'h100 + i));
        end
        async_data_i = 41'h104;
        async_req_i  = ~async_req_i;
        ack_hold     = async_ack_o;
        for (int i = 0; i < 6; i++) tick();
        n_cmp += 4;
        if (count_o !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count_o); end
        if (ack_edges - base !== 4) begin n_fail++; $display("FAIL fill_ack_toggles: got %0d want 4", ack_edges - base); end
        if (async_ack_o !== ack_hold) begin n_fail++; $display("FAIL fill_ack_held: got %0b want %0b", async_ack_o, ack_hold); end
        if (data_o !== 41'h100) begin n_fail++; $display("FAIL fill_head: got %h want 100", data_o); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        n_cmp += 2;
        if (count_o !== 3'd3) begin n_fail++; $display("FAIL stall_pop_count: got %0d want 3", count_o); end
        if (async_ack_o !== ack_hold) begin n_fail++; $display("FAIL stall_no_bypass: ack got %0b want %0b", async_ack_o, ack_hold); end
        tick();
        n_cmp += 3;
        if (count_o !== 3'd4) begin n_fail++; $display("FAIL stall_fifth_count: got %0d want 4", count_o); end
        if (ack_edges - base !== 5) begin n_fail++; $display("FAIL stall_fifth_toggles: got %0d want 5", ack_edges - base); end
        if (async_ack_o !== async_req_i) begin n_fail++; $display("FAIL stall_fifth_ack: got %0b want %0b", async_ack_o, async_req_i); end
        for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(32'h100 + i));
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp += 2;
            if (valid_o !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %0b want 1", i, valid_o); end
            if (data_o !== exp_q[0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_o, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
        end
        ready_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count_o); end
    endtask

    task automatic test_order_wrap();
        int got;
        got = 0;
        exp_q.delete();
        for (int i = 1; i <= 10; i++) exp_q.push_back(DW'(i));
        fork
            begin
                for (int i = 1; i <= 10; i++) send_wait(DW'(i));
            end
            begin
                for (int c = 0; c < 600 && got < 10; c++) begin
                    ready_i = 1'($urandom_range(0, 1));
                    if (valid_o && ready_i) begin
                        n_cmp++;
                        if (data_o !== exp_q[0]) begin
                            n_fail++;
                            $display("FAIL order_data[%0d]: got %h want %h", got, data_o, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                        got++;
                    end
                    tick();
                end
                ready_i = 1'b0;
            end
        join
        tick();
        n_cmp += 2;
        if (got !== 10) begin n_fail++; $display("FAIL order_count: got %0d want 10", got); end
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL order_empty: valid got %0b want 0", valid_o); end
    endtask

    task automatic test_push_pop();
        send_wait(41'h201);
        send_wait(41'h202);
        async_data_i = 41'h203;
        async_req_i  = ~async_req_i;
        tick();
        tick();
        n_cmp++;
        if (count_o !== 3'd2) begin n_fail++; $display("FAIL pp_pre_count: got %0d want 2", count_o); end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        n_cmp += 3;
        if (count_o !== 3'd2) begin n_fail++; $display("FAIL pp_count: got %0d want 2", count_o); end
        if (data_o !== 41'h202) begin n_fail++; $display("FAIL pp_head: got %h want 202", data_o); end
        if (async_ack_o !== async_req_i) begin n_fail++; $display("FAIL pp_ack: got %0b want %0b", async_ack_o, async_req_i); end
    endtask

    task automatic test_clear();
        send_wait(41'h204);
        n_cmp++;
        if (count_o !== 3'd3) begin n_fail++; $display("FAIL clr_pre_count: got %0d want 3", count_o); end
        async_data_i = 41'h205;
        async_req_i  = ~async_req_i;
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_cmp += 3;
        if (count_o !== 3'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", count_o); end
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %0b want 0", valid_o); end
        if (async_ack_o !== 1'b0) begin n_fail++; $display("FAIL clr_ack: got %0b want 0", async_ack_o); end
        // Request still high after clear is seen as a fresh word.
        tick();
        n_cmp += 3;
        if (count_o !== 3'd1) begin n_fail++; $display("FAIL clr_repush_count: got %0d want 1", count_o); end
        if (data_o !== 41'h205) begin n_fail++; $display("FAIL clr_repush_data: got %h want 205", data_o); end
        if (async_ack_o !== 1'b1) begin n_fail++; $display("FAIL clr_repush_ack: got %0b want 1", async_ack_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_wait(41'h301);
        send_wait(41'h302);
        n_cmp++;
        if (count_o !== 3'd2) begin n_fail++; $display("FAIL rst_pre_count: got %0d want 2", count_o); end
        async_data_i = 41'h303;
        async_req_i  = ~async_req_i;
        tick();
        rst_i       = 1'b1;
        async_req_i = 1'b0;
        tick();
        n_cmp += 3;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0b want 0", valid_o); end
        if (count_o !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", count_o); end
        if (async_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %0b want 0", async_ack_o); end
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (count_o !== 3'd0) begin n_fail++; $display("FAIL rst_after_count: got %0d want 0", count_o); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_stall();
        test_order_wrap();
        test_push_pop();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
